// File: rtl/wb_pkg.sv
// Shared types for the writeback arbiter: register-file write request and
// the grant source used to steer the output register.
package wb_pkg;

    localparam int RF_ADDR_W = 5;
    localparam int RF_DATA_W = 32;

    typedef struct packed {
        logic [RF_ADDR_W-1:0] waddr;
        logic [RF_DATA_W-1:0] wdata;
    } wb_req_t;

    typedef enum logic [1:0] {
        WB_SRC_NONE,
        WB_SRC_EX,
        WB_SRC_LSU
    } wb_src_e;

    // x0 is hardwired to zero, so a write to it is never performed.
    function automatic logic addr_writes(input logic [RF_ADDR_W-1:0] addr);
        return addr != '0;
    endfunction

endpackage

// File: rtl/wb_fifo.sv
// DEPTH-entry FIFO of pending EX writeback requests. Push while full and pop
// while empty are ignored; pointers wrap naturally because DEPTH is a power of 2.
module wb_fifo
    import wb_pkg::*;
#(
    parameter int DEPTH = 2,
    localparam int PTR_W = $clog2(DEPTH),
    localparam int CNT_W = PTR_W + 1
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  wb_req_t          data_i,
    input  logic             pop_i,
    output wb_req_t          data_o,
    output logic             full_o,
    output logic             empty_o,
    output logic [CNT_W-1:0] count_o
);

    wb_req_t          mem_q [DEPTH];
    logic [PTR_W-1:0] wptr_q, wptr_d;
    logic [PTR_W-1:0] rptr_q, rptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CNT_W'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign data_o  = mem_q[rptr_q];

    assign do_push = push_i && !full_o;
    assign do_pop  = pop_i && !empty_o;

    always_comb begin
        wptr_d  = wptr_q;
        rptr_d  = rptr_q;
        count_d = count_q;
        if (do_push) begin
            wptr_d = wptr_q + 1'b1;
        end
        if (do_pop) begin
            rptr_d = rptr_q + 1'b1;
        end
        case ({do_push, do_pop})
            2'b10:   count_d = count_q + 1'b1;
            2'b01:   count_d = count_q - 1'b1;
            default: count_d = count_q;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            wptr_q  <= wptr_d;
            rptr_q  <= rptr_d;
            count_q <= count_d;
        end
    end

    // Storage needs no reset: an entry is only read after it has been pushed.
    always_ff @(posedge clk_i) begin
        if (do_push) begin
            mem_q[wptr_q] <= data_i;
        end
    end

endmodule

// File: rtl/wb_write_arbiter.sv
// Arbitrates the single register-file write port between buffered EX results
// and LSU load data: LSU wins, a starvation counter forces EX through.
//
// Handshakes: a transfer happens on a cycle where valid and ready are both
// high; ready never depends on valid, and the producer holds valid and its
// payload stable until the transfer completes.
module wb_write_arbiter
    import wb_pkg::*;
#(
    parameter int DEPTH        = 2,
    parameter int STARVE_LIMIT = 4
) (
    input  logic                 clk_i,
    input  logic                 rst_ni,
    input  logic                 ex_valid_i,
    output logic                 ex_ready_o,
    input  logic                 ex_we_i,
    input  logic [RF_ADDR_W-1:0] ex_waddr_i,
    input  logic [RF_DATA_W-1:0] ex_wdata_i,
    input  logic                 lsu_valid_i,
    output logic                 lsu_ready_o,
    input  logic [RF_ADDR_W-1:0] lsu_waddr_i,
    input  logic [RF_DATA_W-1:0] lsu_wdata_i,
    output logic                 rf_we_o,
    output logic [RF_ADDR_W-1:0] rf_waddr_o,
    output logic [RF_DATA_W-1:0] rf_wdata_o,
    output logic                 ex_pending_o
);

    localparam int CNT_W    = $clog2(DEPTH) + 1;
    localparam int STARVE_W = $clog2(STARVE_LIMIT + 1);
    localparam logic [STARVE_W-1:0] STARVE_MAX = STARVE_W'(STARVE_LIMIT);

    wb_req_t             ex_req;
    wb_req_t             fifo_head;
    logic                fifo_push, fifo_pop;
    logic                fifo_full, fifo_empty;
    logic [CNT_W-1:0]    fifo_count;
    logic                unused_count;

    wb_src_e             grant_src;
    logic                lsu_hs;
    logic                starved;
    logic [STARVE_W-1:0] starve_q, starve_d;

    logic                rf_we_q, rf_we_d;
    wb_req_t             rf_q, rf_d;

    assign ex_req = '{waddr: ex_waddr_i, wdata: ex_wdata_i};

    wb_fifo #(
        .DEPTH(DEPTH)
    ) u_ex_fifo (
        .clk_i  (clk_i),
        .rst_ni (rst_ni),
        .push_i (fifo_push),
        .data_i (ex_req),
        .pop_i  (fifo_pop),
        .data_o (fifo_head),
        .full_o (fifo_full),
        .empty_o(fifo_empty),
        .count_o(fifo_count)
    );

    assign unused_count = ^fifo_count;

    // Both readies come from registered state only, so neither producer sees
    // a combinational path from its own valid.
    assign starved      = !fifo_empty && (starve_q == STARVE_MAX);
    assign lsu_ready_o  = !starved;
    assign ex_ready_o   = !fifo_full;
    assign ex_pending_o = !fifo_empty;

    // Writes that would never reach the RF are consumed here instead of queued.
    assign fifo_push = ex_valid_i && ex_ready_o && ex_we_i && addr_writes(ex_waddr_i);
    assign lsu_hs    = lsu_valid_i && lsu_ready_o;

    always_comb begin
        grant_src = WB_SRC_NONE;
        if (lsu_hs && addr_writes(lsu_waddr_i)) begin
            grant_src = WB_SRC_LSU;
        end else if (!fifo_empty) begin
            grant_src = WB_SRC_EX;
        end
    end

    assign fifo_pop = (grant_src == WB_SRC_EX);

    always_comb begin
        starve_d = starve_q;
        if (fifo_empty || grant_src == WB_SRC_EX) begin
            starve_d = '0;
        end else if (grant_src == WB_SRC_LSU && starve_q != STARVE_MAX) begin
            starve_d = starve_q + 1'b1;
        end
    end

    // Address/data hold their last written value on idle cycles.
    always_comb begin
        rf_we_d = 1'b0;
        rf_d    = rf_q;
        case (grant_src)
            WB_SRC_LSU: begin
                rf_we_d = 1'b1;
                rf_d    = '{waddr: lsu_waddr_i, wdata: lsu_wdata_i};
            end
            WB_SRC_EX: begin
                rf_we_d = 1'b1;
                rf_d    = fifo_head;
            end
            default: begin
                rf_we_d = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            starve_q <= '0;
            rf_we_q  <= 1'b0;
            rf_q     <= '0;
        end else begin
            starve_q <= starve_d;
            rf_we_q  <= rf_we_d;
            rf_q     <= rf_d;
        end
    end

    assign rf_we_o    = rf_we_q;
    assign rf_waddr_o = rf_q.waddr;
    assign rf_wdata_o = rf_q.wdata;

endmodule

// File: tb/tb_wb_write_arbiter.sv
// Bench for wb_write_arbiter: a queue-based reference model predicts the
// RF write of every cycle; a monitor compares the registered write port.
module tb_wb_write_arbiter;

    localparam int DEPTH = 2;
    localparam int LIMIT = 2;

    logic        clk;
    logic        rst_ni;
    logic        ex_valid_i, ex_we_i, lsu_valid_i;
    logic [4:0]  ex_waddr_i, lsu_waddr_i;
    logic [31:0] ex_wdata_i, lsu_wdata_i;
    logic        ex_ready_o, lsu_ready_o, rf_we_o, ex_pending_o;
    logic [4:0]  rf_waddr_o;
    logic [31:0] rf_wdata_o;

    wb_write_arbiter #(
        .DEPTH       (DEPTH),
        .STARVE_LIMIT(LIMIT)
    ) dut (
        .clk_i       (clk),
        .rst_ni      (rst_ni),
        .ex_valid_i  (ex_valid_i),
        .ex_ready_o  (ex_ready_o),
        .ex_we_i     (ex_we_i),
        .ex_waddr_i  (ex_waddr_i),
        .ex_wdata_i  (ex_wdata_i),
        .lsu_valid_i (lsu_valid_i),
        .lsu_ready_o (lsu_ready_o),
        .lsu_waddr_i (lsu_waddr_i),
        .lsu_wdata_i (lsu_wdata_i),
        .rf_we_o     (rf_we_o),
        .rf_waddr_o  (rf_waddr_o),
        .rf_wdata_o  (rf_wdata_o),
        .ex_pending_o(ex_pending_o)
    );

    // ---------------- clock / reset ----------------
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    typedef struct packed {
        logic        we;
        logic [4:0]  a;
        logic [31:0] d;
    } wr_t;

    wr_t exp_q[$];     // expected write-port value, one entry per driven cycle
    wr_t mq[$];        // model of the EX buffer contents
    wr_t ex_src[$];    // pending EX offers (we, addr, data)
    wr_t lsu_src[$];   // pending LSU offers (addr, data)
    wr_t ex_cur, lsu_cur, mon_w;
    bit  ex_busy, lsu_busy;
    int  ex_rate, lsu_rate;
    int  starve;
    logic [4:0]  last_a;
    logic [31:0] last_d;
    int  total, bad;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // ---------------- driver + reference model ----------------
    task automatic step();
        int  cnt;
        bit  exp_er, exp_lr, lsu_hs, lsu_win, ex_win;
        wr_t w, h;
        @(negedge clk);
        if (!ex_busy && ex_src.size() > 0 && int'($urandom_range(99)) < ex_rate) begin
            ex_cur  = ex_src.pop_front();
            ex_busy = 1'b1;
        end
        if (!lsu_busy && lsu_src.size() > 0 && int'($urandom_range(99)) < lsu_rate) begin
            lsu_cur  = lsu_src.pop_front();
            lsu_busy = 1'b1;
        end
        ex_valid_i  = ex_busy;
        ex_we_i     = ex_cur.we;
        ex_waddr_i  = ex_cur.a;
        ex_wdata_i  = ex_cur.d;
        lsu_valid_i = lsu_busy;
        lsu_waddr_i = lsu_cur.a;
        lsu_wdata_i = lsu_cur.d;
        #1;
        cnt    = mq.size();
        exp_er = (cnt != DEPTH);
        exp_lr = !(cnt > 0 && starve == LIMIT);
        chk("ex_ready", 32'(ex_ready_o), 32'(exp_er));
        chk("lsu_ready", 32'(lsu_ready_o), 32'(exp_lr));
        chk("ex_pending", 32'(ex_pending_o), 32'(cnt > 0));

        lsu_hs  = lsu_busy && exp_lr;
        lsu_win = lsu_hs && (lsu_cur.a != 5'd0);
        ex_win  = 1'b0;
        if (lsu_win) begin
            w = '{we: 1'b1, a: lsu_cur.a, d: lsu_cur.d};
        end else if (cnt > 0) begin
            h      = mq.pop_front();
            w      = '{we: 1'b1, a: h.a, d: h.d};
            ex_win = 1'b1;
        end else begin
            w = '{we: 1'b0, a: last_a, d: last_d};
        end
        if (w.we) begin
            last_a = w.a;
            last_d = w.d;
        end
        exp_q.push_back(w);

        if (cnt == 0 || ex_win) starve = 0;
        else if (lsu_win && starve < LIMIT) starve++;

        if (ex_busy && exp_er) begin
            if (ex_cur.we && ex_cur.a != 5'd0) mq.push_back(ex_cur);
            ex_busy = 1'b0;
        end
        if (lsu_hs) lsu_busy = 1'b0;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    task automatic push_ex(input logic we, input logic [4:0] a, input logic [31:0] d);
        ex_src.push_back('{we: we, a: a, d: d});
    endtask

    task automatic push_lsu(input logic [4:0] a, input logic [31:0] d);
        lsu_src.push_back('{we: 1'b1, a: a, d: d});
    endtask

    task automatic drain();
        int budget;
        budget = 0;
        while ((ex_src.size() > 0 || lsu_src.size() > 0 || ex_busy || lsu_busy || mq.size() > 0)
               && budget < 400) begin
            step();
            budget++;
        end
        if (budget >= 400) begin
            total++;
            bad++;
            $display("FAIL drain_timeout: got %0d cycles want <400", budget);
        end
        run(2);
    endtask

    function automatic logic [4:0] rand_addr();
        if ($urandom_range(7) == 0) return 5'd0;
        return 5'($urandom_range(1, 31));
    endfunction

    task automatic random_phase(input int n, input int er, input int lr);
        ex_rate  = er;
        lsu_rate = lr;
        for (int i = 0; i < n; i++) begin
            if (ex_src.size() < 2) push_ex(($urandom_range(7) != 0), rand_addr(), $urandom);
            if (lsu_src.size() < 2) push_lsu(rand_addr(), $urandom);
            step();
        end
        ex_rate  = 100;
        lsu_rate = 100;
        drain();
    endtask

    task automatic model_reset();
        exp_q.delete();
        mq.delete();
        ex_src.delete();
        lsu_src.delete();
        ex_busy  = 1'b0;
        lsu_busy = 1'b0;
        starve   = 0;
        last_a   = '0;
        last_d   = '0;
    endtask

    task automatic check_reset_outputs(input string tag);
        chk({tag, "_rf_we"}, 32'(rf_we_o), 32'd0);
        chk({tag, "_rf_waddr"}, 32'(rf_waddr_o), 32'd0);
        chk({tag, "_rf_wdata"}, rf_wdata_o, 32'd0);
        chk({tag, "_ex_pending"}, 32'(ex_pending_o), 32'd0);
    endtask

    // ---------------- scoreboard monitor ----------------
    always @(negedge clk) begin
        if (rst_ni && exp_q.size() > 0) begin
            mon_w = exp_q.pop_front();
            chk("rf_we", 32'(rf_we_o), 32'(mon_w.we));
            chk("rf_waddr", 32'(rf_waddr_o), 32'(mon_w.a));
            chk("rf_wdata", rf_wdata_o, mon_w.d);
        end
    end

    // ---------------- stimulus ----------------
    initial begin
        total       = 0;
        bad         = 0;
        ex_rate     = 100;
        lsu_rate    = 100;
        ex_cur      = '0;
        lsu_cur     = '0;
        model_reset();
        rst_ni      = 1'b0;
        ex_valid_i  = 1'b0;
        ex_we_i     = 1'b0;
        ex_waddr_i  = '0;
        ex_wdata_i  = '0;
        lsu_valid_i = 1'b0;
        lsu_waddr_i = '0;
        lsu_wdata_i = '0;

        repeat (2) @(negedge clk);
        #1;
        check_reset_outputs("por");
        #1;
        rst_ni = 1'b1;

        // EX only: accept cycle 0, write visible two cycles later
        push_ex(1'b1, 5'd5, 32'hA5A5_A5A5);
        run(4);

        // LSU only: write visible next cycle
        push_lsu(5'd7, 32'h0000_1234);
        run(3);

        // starvation: EX x3 waits behind a continuous LSU stream
        push_ex(1'b1, 5'd3, 32'h33);
        for (int a = 8; a <= 11; a++) push_lsu(5'(a), 32'(a) * 32'h101);
        run(8);

        // backpressure: LSU saturating, EX x1 x2 x4 back-to-back
        for (int a = 12; a < 22; a++) push_lsu(5'(a), 32'hC000_0000 + 32'(a));
        push_ex(1'b1, 5'd1, 32'h1111);
        push_ex(1'b1, 5'd2, 32'h2222);
        push_ex(1'b1, 5'd4, 32'h4444);
        run(14);
        drain();

        // drops: x0 EX, we=0 EX, x0 LSU
        push_ex(1'b1, 5'd0, 32'hFFFF_FFFF);
        push_ex(1'b0, 5'd9, 32'h9999_9999);
        push_lsu(5'd0, 32'hDEAD_BEEF);
        run(5);

        random_phase(400, 50, 60);
        random_phase(300, 90, 100);

        // reset mid-operation: two EX entries buffered, LSU write in flight
        for (int a = 20; a < 26; a++) push_lsu(5'(a), 32'hAB00_0000 + 32'(a));
        push_ex(1'b1, 5'd13, 32'h1313);
        push_ex(1'b1, 5'd14, 32'h1414);
        push_ex(1'b1, 5'd15, 32'h1515);
        run(3);
        @(negedge clk);
        #2;
        rst_ni      = 1'b0;
        ex_valid_i  = 1'b0;
        lsu_valid_i = 1'b0;
        model_reset();
        #1;
        check_reset_outputs("midrst");
        repeat (2) @(negedge clk);
        #2;
        rst_ni = 1'b1;
        run(5);

        random_phase(150, 70, 70);

        @(negedge clk);
        #2;
        chk("exp_q_left", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/wb_write_arbiter.md
Name: wb_write_arbiter

Overview:
- Sequences and shares the single register-file write port between two producers: EX-stage results and LSU load data.
- EX results are buffered in a small FIFO. LSU data has priority, and a starvation counter guarantees EX progress.
- Sits between EX/LSU and the register file and replaces the fixed EX/LSU OR-merge at writeback with a registered, arbitrated write port.

Parameters:
- DEPTH, 2, EX buffer entries (power of 2, >=2).
- STARVE_LIMIT, 4, max consecutive LSU grants while an EX entry waits (>=1).

Ports:
- clk_i  in  1  clock, rising edge.
- rst_ni  in  1  asynchronous active-low reset.
- ex_valid_i  in  1  EX result offered.
- ex_ready_o  out  1  EX result accepted this cycle when valid&ready.
- ex_we_i  in  1  EX result writes RF.
- ex_waddr_i  in  5  EX destination register.
- ex_wdata_i  in  32  EX write data.
- lsu_valid_i  in  1  LSU load data offered.
- lsu_ready_o  out  1  LSU data accepted when valid&ready.
- lsu_waddr_i  in  5  LSU destination register.
- lsu_wdata_i  in  32  LSU load data.
- rf_we_o  out  1  RF write enable (registered).
- rf_waddr_o  out  5  RF write address (registered).
- rf_wdata_o  out  32  RF write data (registered).
- ex_pending_o  out  1  EX FIFO non-empty, used by ID hazard logic.

Behaviour:
- Reset (async, rst_ni=0): FIFO count, pointers and starve_cnt cleared. rf_we_o=0, rf_waddr_o=0, rf_wdata_o=0, ex_pending_o=0. After release, ex_ready_o=1 and lsu_ready_o=1.
- EX accept:
  - ex_ready_o = (count != DEPTH), computed from registered count only. No same-cycle enqueue-on-dequeue when full.
  - An accepted transfer with ex_we_i=0 or ex_waddr_i=0 is consumed and dropped (not enqueued).
- Candidates each cycle:
  - EX = FIFO head if count>0.
  - LSU = lsu_valid_i. LSU with waddr=0 is handshaken (lsu_ready_o permitting) but never written.
- Arbitration:
  - lsu_ready_o = !(count>0 && starve_cnt==STARVE_LIMIT); this depends on state only.
  - If LSU handshakes with waddr!=0, LSU is granted.
  - Else if count>0, EX head is granted and dequeued.
  - Else no grant.
  - An LSU x0 handshake does not block EX: EX is granted in that cycle.
- Starve counter:
  - +1, saturating at STARVE_LIMIT, when count>0 and LSU is granted.
  - Cleared when EX is granted or count==0.
- Output register:
  - On grant: rf_we_o<=1, waddr/wdata <= winner.
  - No grant: rf_we_o<=0, waddr/wdata hold their last value.
  - Never more than one write per cycle.
- Latency:
  - LSU: handshake in cycle N -> rf_we_o in N+1.
  - EX: accept in N -> earliest rf_we_o in N+2 (FIFO stage, then output register).
- Ordering: EX entries retire in FIFO order. No ordering guarantee between EX and LSU; the ID scoreboard owns WAW.
- ex_pending_o = (count>0), registered-state derived.
- Full FIFO with simultaneous EX grant: dequeue happens, enqueue is refused that cycle, ex_ready_o rises next cycle.
- Pointers wrap modulo DEPTH.

Decomposition:
- Package wb_pkg holds:
  - wb_req_t struct {logic [4:0] waddr; logic [31:0] wdata;}
  - enum wb_src_e {WB_SRC_NONE, WB_SRC_EX, WB_SRC_LSU}
  - RF_ADDR_W=5, RF_DATA_W=32.
- Sub-module wb_fifo (DEPTH x wb_req_t, push/pop/full/empty/count, async active-low reset) holds the EX buffer. Arbitration, starve counter and output register stay in the top.

Test Plan:
- EX only: cycle0 ex_valid_i=1, we=1, waddr=5, wdata=0xA5A5A5A5 -> cycle2 rf_we_o=1, rf_waddr_o=5, rf_wdata_o=0xA5A5A5A5; cycle3 rf_we_o=0; ex_pending_o high only in cycle1.
- LSU only: cycle0 lsu_valid_i=1, waddr=7, wdata=0x00001234 -> cycle1 rf_we_o=1, addr 7, data 0x1234; lsu_ready_o stays 1.
- Starvation, STARVE_LIMIT=2:
  - Stimulus: EX x3=0x33 enqueued, LSU valid every cycle with x8..x11.
  - Required: LSU written 2 cycles, then lsu_ready_o=0 for one cycle, x3=0x33 written, starve_cnt=0, LSU resumes.
- Backpressure, DEPTH=2:
  - Stimulus: LSU saturating and STARVE_LIMIT large; EX offers x1, x2, x4 back-to-back.
  - Required: x1 and x2 accepted, ex_ready_o=0 while x4 holds stable. After first EX drain ex_ready_o=1 next cycle; writes retire in order x1, x2, x4.
- Drops: EX waddr=0, wdata=0xFFFFFFFF and EX we=0, waddr=9 -> both handshaken, rf_we_o never asserts, count stays 0. LSU waddr=0 -> lsu_ready_o=1, no write.
- Reset mid-operation: FIFO holds 2 entries and a write is in flight; drive rst_ni=0 -> rf_we_o/addr/data=0 immediately, entries discarded. After release ex_ready_o=1, no spurious writes.
